// File: rtl/vault_door_controller.sv
// Vault door actuation: bolt retract/extend sequencing, unlock window, held-open buzzer,
// forced-entry and bolt-jam fault handling with synchronised sensor inputs.
module vault_door_controller #(
    parameter int unsigned TICK_DIV      = 1000,
    parameter int unsigned BOLT_TIMEOUT  = 50,
    parameter int unsigned UNLOCK_WINDOW = 200,
    parameter int unsigned OPEN_MAX      = 600,
    parameter int unsigned TW            = 12
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VaultGrant,
    input  logic       OpenReq,
    input  logic       DoorClosed,
    input  logic       BoltRetracted,
    output logic       BoltDrive,
    output logic       Buzzer,
    output logic       Alarm,
    output logic       LedUnlocked,
    output logic [2:0] State
);

    localparam logic [2:0] LOCKED    = 3'd0;
    localparam logic [2:0] RETRACT   = 3'd1;
    localparam logic [2:0] UNLOCKED  = 3'd2;
    localparam logic [2:0] DOOR_OPEN = 3'd3;
    localparam logic [2:0] EXTEND    = 3'd4;
    localparam logic [2:0] FAULT     = 3'd5;

    localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]  BOLT_LIM   = TW'(BOLT_TIMEOUT);
    localparam logic [TW-1:0]  WINDOW_LIM = TW'(UNLOCK_WINDOW);
    localparam logic [TW-1:0]  OPEN_LIM   = TW'(OPEN_MAX);

    logic grantS1, grantS2;
    logic openS1, openS2, openS3;
    logic doorS1, doorS2;
    logic boltS1, boltS2;
    logic openEdge;

    logic [PW-1:0] prescaler;
    logic          tick;
    logic [TW-1:0] timer;
    logic [TW-1:0] timerNext;
    logic [2:0]    stateNext;

    // Door sensor synchroniser resets to "closed" so release of Reset cannot look like forced entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            grantS1 <= 1'b0;
            grantS2 <= 1'b0;
            openS1  <= 1'b0;
            openS2  <= 1'b0;
            openS3  <= 1'b0;
            doorS1  <= 1'b1;
            doorS2  <= 1'b1;
            boltS1  <= 1'b0;
            boltS2  <= 1'b0;
        end else begin
            grantS1 <= VaultGrant;
            grantS2 <= grantS1;
            openS1  <= OpenReq;
            openS2  <= openS1;
            openS3  <= openS2;
            doorS1  <= DoorClosed;
            doorS2  <= doorS1;
            boltS1  <= BoltRetracted;
            boltS2  <= boltS1;
        end
    end

    assign openEdge = openS2 & ~openS3;
    assign tick     = (prescaler == PRESC_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prescaler <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    always_comb begin
        stateNext = State;
        case (State)
            LOCKED: begin
                if (!doorS2)                   stateNext = FAULT;
                else if (grantS2 && openEdge)  stateNext = RETRACT;
            end
            RETRACT: begin
                if (!grantS2)                  stateNext = EXTEND;
                else if (boltS2)               stateNext = UNLOCKED;
                else if (timer >= BOLT_LIM)    stateNext = FAULT;
            end
            UNLOCKED: begin
                if (!doorS2)                   stateNext = DOOR_OPEN;
                else if (!grantS2 || timer >= WINDOW_LIM) stateNext = EXTEND;
            end
            DOOR_OPEN: begin
                if (doorS2)                    stateNext = EXTEND;
            end
            EXTEND: begin
                if (!doorS2)                   stateNext = DOOR_OPEN;
                else if (!boltS2)              stateNext = LOCKED;
                else if (timer >= BOLT_LIM)    stateNext = FAULT;
            end
            FAULT: begin
                if (grantS2 && openEdge && doorS2 && !boltS2) stateNext = LOCKED;
            end
            default: stateNext = FAULT;
        endcase
    end

    always_comb begin
        timerNext = timer;
        if (stateNext != State) begin
            timerNext = '0;
        end else if (tick && (timer != '1)) begin
            timerNext = timer + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as State.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            State       <= LOCKED;
            timer       <= '0;
            BoltDrive   <= 1'b0;
            Buzzer      <= 1'b0;
            Alarm       <= 1'b0;
            LedUnlocked <= 1'b0;
        end else begin
            State       <= stateNext;
            timer       <= timerNext;
            BoltDrive   <= (stateNext == RETRACT) || (stateNext == UNLOCKED) ||
                           (stateNext == DOOR_OPEN);
            LedUnlocked <= (stateNext == UNLOCKED) || (stateNext == DOOR_OPEN);
            Alarm       <= (stateNext == FAULT);
            Buzzer      <= (stateNext == DOOR_OPEN) && ((timerNext >= OPEN_LIM) || !grantS2);
        end
    end

endmodule

// File: doc/vault_door_controller.md
Name: vault_door_controller

Overview:
- Actuation end of the vault-access path: consumes the vault grant level from the authentication logic and runs the physical bolt/door sequence.
- Handles bolt retract and extend with limit-switch feedback, the unlock window, the door-held-open buzzer, forced-entry detection and bolt-jam faults.
- Sits between the authentication block and the lock solenoid driver, door reed sensor and bolt limit switch.

Parameters:
- TICK_DIV, 1000: Clk cycles per timer tick; prescaler wraps at TICK_DIV-1.
- BOLT_TIMEOUT, 50: ticks allowed for the bolt to reach its end position.
- UNLOCK_WINDOW, 200: ticks the bolt stays retracted waiting for the door to open.
- OPEN_MAX, 600: ticks the door may stay open before the buzzer sounds.
- TW, 12: state-timer width; must hold the largest tick parameter.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- VaultGrant  in  1  level from authentication logic; 1 = access granted.
- OpenReq  in  1  door-open pushbutton; the rising edge is the request.
- DoorClosed  in  1  door reed sensor; 1 = closed.
- BoltRetracted  in  1  bolt limit switch; 1 = fully retracted.
- BoltDrive  out  1  solenoid drive; 1 = retract, 0 = extend.
- Buzzer  out  1  door-held-open / grant-lost warning.
- Alarm  out  1  forced-entry or jam alarm.
- LedUnlocked  out  1  1 in UNLOCKED and DOOR_OPEN.
- State  out  3  current state code, for debug.

Behaviour:
- Input synchronisation:
  - All four inputs pass through 2-FF synchronizers.
  - Reset values: VaultGrant 0, OpenReq 0, BoltRetracted 0, DoorClosed 1 (so no false fault after reset).
  - OpenReq edge = sync2 & ~sync3.
- Reset: State=LOCKED(0), BoltDrive=0, Buzzer=0, Alarm=0, LedUnlocked=0, prescaler=0, timer=0.
- Outputs are registered and update on the same edge as State.
- Latency: a raw OpenReq rise sampled at edge k, with grant already high, gives State=RETRACT and BoltDrive=1 after edge k+2.
- Timer:
  - Prescaler produces a one-cycle tick every TICK_DIV cycles.
  - The state timer increments on tick, saturates at all-ones, and clears on every state change.
  - Every comparison is timer >= parameter.
- States (code):
  - LOCKED(0): BoltDrive=0.
    - ~DoorClosed -> FAULT (forced entry).
    - Else grant & OpenReq edge -> RETRACT.
    - OpenReq without grant is ignored.
  - RETRACT(1): BoltDrive=1.
    - ~grant -> EXTEND.
    - Else BoltRetracted -> UNLOCKED.
    - Else timer>=BOLT_TIMEOUT -> FAULT.
  - UNLOCKED(2): BoltDrive=1, LedUnlocked=1.
    - ~DoorClosed -> DOOR_OPEN.
    - Else ~grant or timer>=UNLOCK_WINDOW -> EXTEND.
  - DOOR_OPEN(3): BoltDrive=1, LedUnlocked=1.
    - Buzzer=1 when timer>=OPEN_MAX or ~grant.
    - DoorClosed -> EXTEND; Buzzer clears on the exit edge.
    - Loss of grant never re-extends the bolt onto an open door.
  - EXTEND(4): BoltDrive=0.
    - ~DoorClosed -> DOOR_OPEN (bolt re-retracts, timer restarts).
    - Else ~BoltRetracted -> LOCKED.
    - Else timer>=BOLT_TIMEOUT -> FAULT.
  - FAULT(5): BoltDrive=0, Alarm=1.
    - Exit to LOCKED only on grant & OpenReq edge & DoorClosed & ~BoltRetracted, or by Reset.
    - The exit clears Alarm.
  - Codes 6 and 7: go to FAULT next cycle.
- Priority for simultaneous conditions in one cycle: fault/door-sensor conditions > grant loss > normal progress > timeout, except where a state lists otherwise.
- Reset mid-operation: immediate return to reset values, including BoltDrive=0 (fail-secure).

Test Plan:
All scenarios use TICK_DIV=4, BOLT_TIMEOUT=8, UNLOCK_WINDOW=16, OPEN_MAX=32.
1. Normal access:
   - Stimulus: grant=1, pulse OpenReq; BoltRetracted=1 after 5 cycles; DoorClosed 0 for 40 cycles then 1; BoltRetracted=0 after 5 cycles.
   - Required: BoltDrive=1 at the 3rd edge after the press; State 1->2->3->4->0; Buzzer stays 0; final BoltDrive=0, LedUnlocked=0.
2. No grant:
   - Stimulus: grant=0, pulse OpenReq 3 times.
   - Required: State stays 0, BoltDrive stays 0.
3. Bolt jam:
   - Stimulus: grant=1, OpenReq; BoltRetracted held 0.
   - Required: FAULT (5) with Alarm=1 after 8 ticks (~32 cycles from RETRACT entry).
   - Then: OpenReq with grant=1, DoorClosed=1 -> State=0, Alarm=0.
4. Forced entry:
   - Stimulus: in LOCKED, DoorClosed=0.
   - Required: State=5, Alarm=1 within 3 cycles; BoltDrive stays 0.
5. Door held open / grant lost:
   - Stimulus: in DOOR_OPEN, hold 32+ ticks.
   - Required: Buzzer=1; dropping grant keeps BoltDrive=1 until DoorClosed=1, then EXTEND.
   - Also: unlock window expiry with the door never opened -> EXTEND after 16 ticks.
6. Reset mid-operation:
   - Stimulus: assert Reset in UNLOCKED.
   - Required: State=0, BoltDrive=0, LedUnlocked=0 asynchronously; no spurious FAULT after release, because DoorClosed sync resets to 1.
